// File: rtl/nibble_serial_adder_if.sv
// Handshake and 4-bit adder-stage bundle for nibble_serial_adder.
// Optional Ovf signal is present only when NIBBLE_SERIAL_ADDER_OVF_EN is defined.
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif
    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic             add_cin;
    logic [3:0]       add_sum;
    logic             add_cout;

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    modport master (
        output in_valid, a, b, cin, out_ready, add_sum, add_cout,
        input  in_ready, out_valid, sum, cout, ovf, add_a, add_b, add_cin
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready, add_sum, add_cout,
        output in_ready, out_valid, sum, cout, ovf, add_a, add_b, add_cin
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready, add_sum, add_cout,
        input  in_ready, out_valid, sum, cout, add_a, add_b, add_cin
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready, add_sum, add_cout,
        output in_ready, out_valid, sum, cout, add_a, add_b, add_cin
    );
`endif
endinterface

// File: rtl/nibble_serial_adder.sv
// Wide adder that reuses one external 4-bit adder stage, one nibble per cycle.
// Define NIBBLE_SERIAL_ADDER_OVF_EN to add the signed-overflow flag (bus.ovf).
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_serial_adder_if.slave bus
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WIDTH-1:0]  op_a_r;
    logic [WIDTH-1:0]  op_b_r;
    logic [WIDTH-1:0]  result_r;
    logic [IDXW-1:0]   idx_r;
    logic              carry_r;
    logic              cout_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              accept_s;
    logic              last_s;
    logic [3:0]        add_a_s;
    logic [3:0]        add_b_s;
    logic              add_cin_s;

    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    assign accept_s = (state_r == IDLE) && bus.in_valid && in_ready_r;
    assign last_s   = (idx_r == IDXW'(NIB - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nxt_s = RUN;
                else          state_nxt_s = IDLE;
            end
            RUN: begin
                if (last_s) state_nxt_s = DONE;
                else        state_nxt_s = RUN;
            end
            DONE: begin
                if (bus.out_ready) state_nxt_s = IDLE;
                else               state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Adder-stage drive comes only from registered operands, never from bus.a/bus.b
    always_comb begin
        add_a_s   = 4'b0000;
        add_b_s   = 4'b0000;
        add_cin_s = 1'b0;
        if (state_r == RUN) begin
            add_a_s   = op_a_r[{idx_r, 2'b00} +: 4];
            add_b_s   = op_b_r[{idx_r, 2'b00} +: 4];
            add_cin_s = carry_r;
        end else begin
            add_a_s   = 4'b0000;
            add_b_s   = 4'b0000;
            add_cin_s = 1'b0;
        end
    end

    // Operand capture, nibble accumulation, carry ripple and handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_r      <= {WIDTH{1'b0}};
            op_b_r      <= {WIDTH{1'b0}};
            result_r    <= {WIDTH{1'b0}};
            idx_r       <= {IDXW{1'b0}};
            carry_r     <= 1'b0;
            cout_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_a_r     <= bus.a;
                        op_b_r     <= bus.b;
                        carry_r    <= bus.cin;
                        idx_r      <= {IDXW{1'b0}};
                        in_ready_r <= 1'b0;
                    end
                end
                RUN: begin
                    result_r[{idx_r, 2'b00} +: 4] <= bus.add_sum;
                    carry_r <= bus.add_cout;
                    if (last_s) begin
                        cout_r      <= bus.add_cout;
                        out_valid_r <= 1'b1;
                    end else begin
                        idx_r <= idx_r + IDXW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic ovf_r;

    // Overflow flag captured as the top nibble lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if ((state_r == RUN) && last_s) begin
            ovf_r <= signed_ovf(op_a_r[WIDTH-1], op_b_r[WIDTH-1], bus.add_sum[3]);
        end
    end

    assign bus.ovf = ovf_r;
`endif

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = result_r;
    assign bus.cout      = cout_r;
    assign bus.add_a     = add_a_s;
    assign bus.add_b     = add_b_s;
    assign bus.add_cin   = add_cin_s;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed testbench for nibble_serial_adder (WIDTH=16) with a behavioural 4-bit adder stage.
module tb_nibble_serial_adder;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    nibble_serial_adder_if #(.WIDTH(16)) bus ();

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural model of the team's 4-bit ripple adder
    assign {bus.add_cout, bus.add_sum} = 5'(bus.add_a) + 5'(bus.add_b) + 5'(bus.add_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_accept(input logic [15:0] av, input logic [15:0] bv, input logic c);
        @(negedge clk);
        bus.a        = av;
        bus.b        = bv;
        bus.cin      = c;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Returns cycles from the accepting edge to OutValid, or -1 after 20 cycles
    task automatic wait_out(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                lat = i - 1;
                break;
            end
        end
    endtask

    task automatic consume();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++;
        if ({bus.in_ready, bus.out_valid, bus.cout} !== 3'b100) begin
            fails++;
            $display("FAIL reset_flags got %b expected 100", {bus.in_ready, bus.out_valid, bus.cout});
        end
        tests++;
        if (bus.sum !== 16'h0000) begin
            fails++;
            $display("FAIL reset_sum got %h expected 0000", bus.sum);
        end
        tests++;
        if ({bus.add_a, bus.add_b, bus.add_cin} !== 9'h000) begin
            fails++;
            $display("FAIL reset_adder got %h expected 000", {bus.add_a, bus.add_b, bus.add_cin});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        do_accept(16'h1234, 16'h4321, 1'b0);
        wait_out(lat);
        tests++;
        if (lat !== 4) begin
            fails++;
            $display("FAIL basic_latency got %0d expected 4", lat);
        end
        tests++;
        if ({bus.cout, bus.sum} !== 17'h05555) begin
            fails++;
            $display("FAIL basic_sum got %h expected 05555", {bus.cout, bus.sum});
        end
        consume();
        tests++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            fails++;
            $display("FAIL basic_release got %b expected 10", {bus.in_ready, bus.out_valid});
        end
    endtask

    task automatic test_adder_if();
        logic [3:0] ea [4];
        logic [3:0] eb [4];
        ea = '{4'h4, 4'h3, 4'h2, 4'h1};
        eb = '{4'h1, 4'h2, 4'h3, 4'h4};
        @(negedge clk);
        tests++;
        if ({bus.add_a, bus.add_b, bus.add_cin} !== 9'h000) begin
            fails++;
            $display("FAIL adder_idle got %h expected 000", {bus.add_a, bus.add_b, bus.add_cin});
        end
        do_accept(16'h1234, 16'h4321, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if ({bus.add_a, bus.add_b, bus.add_cin} !== {ea[i], eb[i], 1'b0}) begin
                fails++;
                $display("FAIL adder_nib%0d got %h expected %h", i,
                         {bus.add_a, bus.add_b, bus.add_cin}, {ea[i], eb[i], 1'b0});
            end
        end
        @(negedge clk);
        tests++;
        if ({bus.out_valid, bus.add_a, bus.add_b, bus.add_cin} !== 10'h200) begin
            fails++;
            $display("FAIL adder_done got %h expected 200",
                     {bus.out_valid, bus.add_a, bus.add_b, bus.add_cin});
        end
        consume();
    endtask

    task automatic test_carry();
        int lat;
        do_accept(16'hFFFF, 16'h0001, 1'b0);
        wait_out(lat);
        tests++;
        if ({bus.cout, bus.sum} !== 17'h10000) begin
            fails++;
            $display("FAIL carry_b got %h expected 10000", {bus.cout, bus.sum});
        end
        consume();
        do_accept(16'hFFFF, 16'h0000, 1'b1);
        wait_out(lat);
        tests++;
        if ({bus.cout, bus.sum} !== 17'h10000) begin
            fails++;
            $display("FAIL carry_cin got %h expected 10000", {bus.cout, bus.sum});
        end
        consume();
    endtask

    task automatic test_busy_hold();
        int lat;
        do_accept(16'h8000, 16'h8000, 1'b1);
        bus.a        = 16'h1000;
        bus.b        = 16'h0234;
        bus.cin      = 1'b0;
        bus.in_valid = 1'b1;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            tests++;
            if (bus.in_ready !== 1'b0) begin
                fails++;
                $display("FAIL busy_ready cycle %0d got %b expected 0", i, bus.in_ready);
            end
            if (bus.out_valid === 1'b1) begin
                lat = i - 1;
                break;
            end
        end
        tests++;
        if (lat !== 4) begin
            fails++;
            $display("FAIL busy_latency got %0d expected 4", lat);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if ({bus.out_valid, bus.in_ready, bus.cout, bus.sum} !== 19'h50001) begin
                fails++;
                $display("FAIL hold_cycle%0d got %h expected 50001", i,
                         {bus.out_valid, bus.in_ready, bus.cout, bus.sum});
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        tests++;
        if ({bus.in_ready, bus.out_valid, bus.sum} !== 18'h20001) begin
            fails++;
            $display("FAIL busy_idle got %h expected 20001", {bus.in_ready, bus.out_valid, bus.sum});
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        tests++;
        if (bus.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL busy_second_accept got %b expected 0", bus.in_ready);
        end
        wait_out(lat);
        tests++;
        if (lat !== 4) begin
            fails++;
            $display("FAIL second_latency got %0d expected 4", lat);
        end
        tests++;
        if ({bus.cout, bus.sum} !== 17'h01234) begin
            fails++;
            $display("FAIL second_sum got %h expected 01234", {bus.cout, bus.sum});
        end
        consume();
    endtask

    task automatic test_ready_early();
        int lat;
        bus.out_ready = 1'b1;
        do_accept(16'h00FF, 16'h0001, 1'b0);
        wait_out(lat);
        tests++;
        if ({bus.cout, bus.sum} !== 17'h00100) begin
            fails++;
            $display("FAIL early_sum got %h expected 00100", {bus.cout, bus.sum});
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        tests++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            fails++;
            $display("FAIL early_release got %b expected 01", {bus.out_valid, bus.in_ready});
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        do_accept(16'hAAAA, 16'h5555, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({bus.in_ready, bus.out_valid, bus.cout, bus.sum} !== 19'h40000) begin
            fails++;
            $display("FAIL midreset_outputs got %h expected 40000",
                     {bus.in_ready, bus.out_valid, bus.cout, bus.sum});
        end
        tests++;
        if ({bus.add_a, bus.add_b, bus.add_cin} !== 9'h000) begin
            fails++;
            $display("FAIL midreset_adder got %h expected 000", {bus.add_a, bus.add_b, bus.add_cin});
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_accept(16'h0F0F, 16'h0101, 1'b0);
        wait_out(lat);
        tests++;
        if (lat !== 4) begin
            fails++;
            $display("FAIL postreset_latency got %0d expected 4", lat);
        end
        tests++;
        if ({bus.cout, bus.sum} !== 17'h01010) begin
            fails++;
            $display("FAIL postreset_sum got %h expected 01010", {bus.cout, bus.sum});
        end
        consume();
    endtask

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    task automatic test_ovf();
        int lat;
        do_accept(16'h7FFF, 16'h0001, 1'b0);
        wait_out(lat);
        tests++;
        if ({bus.ovf, bus.cout, bus.sum} !== 18'h28000) begin
            fails++;
            $display("FAIL ovf_pos got %h expected 28000", {bus.ovf, bus.cout, bus.sum});
        end
        consume();
        do_accept(16'hFFFF, 16'h0001, 1'b0);
        wait_out(lat);
        tests++;
        if ({bus.ovf, bus.cout, bus.sum} !== 18'h10000) begin
            fails++;
            $display("FAIL ovf_neg got %h expected 10000", {bus.ovf, bus.cout, bus.sum});
        end
        consume();
    endtask
`endif

    initial begin
        tests         = 0;
        fails         = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = 16'h0000;
        bus.b         = 16'h0000;
        bus.cin       = 1'b0;
        test_reset();
        test_basic();
        test_adder_if();
        test_carry();
        test_busy_hold();
        test_ready_early();
        test_reset_mid();
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
        test_ovf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
